// File: rtl/fcd_pkg.sv
// ----------------------------------------------------------------------------
// fcd_pkg: shared encodings, FSM state type and width helper for the decoder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fcd_pkg;

    localparam logic FCD_MODE_UNARY  = 1'b0;
    localparam logic FCD_MODE_BINARY = 1'b1;

    typedef enum logic [0:0] {
        FCD_SETTLE = 1'b0,
        FCD_STABLE = 1'b1
    } fcd_state_e;

    // Width that holds the sum of all hands even when every hand reads 2^FINGERS-1.
    function automatic int fcd_sum_w(input int hands, input int fingers);
        return fingers + $clog2(hands + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fcd_hand_decode.sv
// ----------------------------------------------------------------------------
// fcd_hand_decode: one hand's finger vector -> unary popcount or binary value.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fcd_hand_decode
    import fcd_pkg::*;
#(
    parameter int FINGERS = 5
) (
    input  logic               mode_i,
    input  logic [FINGERS-1:0] fingers_i,
    output logic [FINGERS-1:0] value_o
);

    logic [FINGERS-1:0] w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < FINGERS; i++) begin
            w_popcount = w_popcount + FINGERS'(fingers_i[i]);
        end
        value_o = (mode_i == FCD_MODE_BINARY) ? fingers_i : w_popcount;
    end

endmodule

`default_nettype wire

// File: rtl/finger_count_decoder.sv
// ----------------------------------------------------------------------------
// finger_count_decoder: synchronised, debounced finger-count decoder with a
// valid/ready result port. Define FCD_ACCUM_EN for the saturating acc_o. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module finger_count_decoder
    import fcd_pkg::*;
#(
    parameter  int HANDS         = 2,
    parameter  int FINGERS       = 5,
    parameter  int STABLE_CYCLES = 4,
    parameter  int ACC_W         = 8,
    localparam int SUM_W         = fcd_sum_w(HANDS, FINGERS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [HANDS*FINGERS-1:0]   hs_i,
    input  logic                       mode_i,
    input  logic                       out_ready_i,
    input  logic                       clr_i,
    output logic [HANDS*FINGERS-1:0]   hand_cnt_o,
    output logic [SUM_W-1:0]           total_o,
    output logic                       out_valid_o,
    output logic                       overrun_o,
    output logic [ACC_W-1:0]           acc_o
);

    localparam int               HW       = HANDS * FINGERS;
    localparam int               WORD_W   = HW + 1;
    localparam int               CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Debounced word is {mode, fingers}: a mode flip restarts settling.
    logic [WORD_W-1:0] sync1_q, sync1_d;
    logic [WORD_W-1:0] sync2_q, sync2_d;
    logic [WORD_W-1:0] prev_q, prev_d;
    logic [WORD_W-1:0] committed_q, committed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fcd_state_e        state_q, state_d;

    logic [HW-1:0]     hand_cnt_q, hand_cnt_d;
    logic [SUM_W-1:0]  total_q, total_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              w_same;
    logic              w_reached;
    logic              w_commit;
    logic [HW-1:0]     w_hand_val;
    logic [SUM_W-1:0]  w_total;

    for (genvar h = 0; h < HANDS; h++) begin : g_hand
        fcd_hand_decode #(
            .FINGERS   (FINGERS)
        ) u_dec (
            .mode_i    (sync2_q[WORD_W-1]),
            .fingers_i (sync2_q[h*FINGERS +: FINGERS]),
            .value_o   (w_hand_val[h*FINGERS +: FINGERS])
        );
    end

    always_comb begin
        w_total = '0;
        for (int h = 0; h < HANDS; h++) begin
            w_total = w_total + SUM_W'(w_hand_val[h*FINGERS +: FINGERS]);
        end
    end

    // cnt counts repeats after the first sample of a run, saturating at the threshold.
    always_comb begin
        sync1_d = {mode_i, hs_i};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        w_same  = (sync2_q == prev_q);

        if (!w_same) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        w_reached = (cnt_d == CNT_LAST);

        state_d  = state_q;
        w_commit = 1'b0;
        case (state_q)
            FCD_SETTLE: begin
                if (w_reached) begin
                    state_d  = FCD_STABLE;
                    w_commit = (sync2_q != committed_q);
                end
            end
            FCD_STABLE: begin
                if (!w_same) begin
                    if (w_reached) begin
                        w_commit = (sync2_q != committed_q);
                    end else begin
                        state_d = FCD_SETTLE;
                    end
                end
            end
            default: state_d = FCD_SETTLE;
        endcase

        committed_d = w_commit ? sync2_q    : committed_q;
        hand_cnt_d  = w_commit ? w_hand_val : hand_cnt_q;
        total_d     = w_commit ? w_total    : total_q;

        if (w_commit) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (w_commit && valid_q && !out_ready_i) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            committed_q <= '0;
            cnt_q       <= '0;
            state_q     <= FCD_SETTLE;
            hand_cnt_q  <= '0;
            total_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hand_cnt_q  <= hand_cnt_d;
            total_q     <= total_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign hand_cnt_o  = hand_cnt_q;
    assign total_o     = total_q;
    assign out_valid_o = valid_q;
    assign overrun_o   = overrun_q;

`ifdef FCD_ACCUM_EN
    localparam int ACC_SUM_W = ACC_W + SUM_W + 1;

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_SUM_W-1:0] w_acc_sum;

    always_comb begin
        w_acc_sum = ACC_SUM_W'(acc_q) + ACC_SUM_W'(total_q);
        if (clr_i) begin
            acc_d = '0;
        end else if (valid_q && out_ready_i) begin
            acc_d = (w_acc_sum > ACC_SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
`else
    assign acc_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_finger_count_decoder.sv
// ----------------------------------------------------------------------------
// tb_finger_count_decoder: directed + randomized bench with a run-length
// reference model and a valid/ready scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_finger_count_decoder;

    localparam int HANDS   = 2;
    localparam int FINGERS = 5;
    localparam int S       = 4;
    localparam int ACC_W   = 8;
    localparam int HW      = HANDS * FINGERS;
    localparam int SUM_W   = FINGERS + $clog2(HANDS + 1);
    localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef FCD_ACCUM_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [HW-1:0]    hs = '0;
    logic             mode = 1'b0;
    logic             ready = 1'b1;
    logic             clr = 1'b0;
    logic [HW-1:0]    hand_cnt_o;
    logic [SUM_W-1:0] total_o;
    logic             out_valid_o;
    logic             overrun_o;
    logic [ACC_W-1:0] acc_o;

    always #5 clk = ~clk;

    finger_count_decoder #(
        .HANDS         (HANDS),
        .FINGERS       (FINGERS),
        .STABLE_CYCLES (S),
        .ACC_W         (ACC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs_i        (hs),
        .mode_i      (mode),
        .out_ready_i (ready),
        .clr_i       (clr),
        .hand_cnt_o  (hand_cnt_o),
        .total_o     (total_o),
        .out_valid_o (out_valid_o),
        .overrun_o   (overrun_o),
        .acc_o       (acc_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [HW-1:0]    hand;
        logic [SUM_W-1:0] total;
    } res_t;

    res_t        exp_q[$];
    logic [HW:0] pipe_q[$];
    logic [HW:0] m_cur, m_committed, m_s;
    int          m_run, m_acc;
    bit          m_pend, m_ovr, m_commit, m_accept, m_ovr_evt;
    res_t        m_disp, m_r;

    function automatic res_t decode(input logic [HW:0] w);
        res_t             r;
        int               tot;
        int               v;
        logic [FINGERS-1:0] f;
        r   = '0;
        tot = 0;
        for (int h = 0; h < HANDS; h++) begin
            f = w[h*FINGERS +: FINGERS];
            v = w[HW] ? int'(f) : $countones(f);
            r.hand[h*FINGERS +: FINGERS] = FINGERS'(v);
            tot += v;
        end
        r.total = SUM_W'(tot);
        return r;
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        exp_q.delete();
        m_cur = '0; m_committed = '0; m_run = 1;
        m_pend = 0; m_ovr = 0; m_disp = '0; m_acc = 0;
    endtask

    // Input reaches the debouncer two edges late; a word commits when its run of
    // consecutive samples first reaches S and it differs from the last commit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_s = pipe_q.pop_front();
            pipe_q.push_back({mode, hs});
            if (m_s == m_cur) begin
                if (m_run <= S) m_run++;
            end else begin
                m_cur = m_s;
                m_run = 1;
            end
            m_commit  = (m_run == S) && (m_s != m_committed);
            m_accept  = m_pend && ready;
            m_ovr_evt = m_commit && m_pend && !ready;
            if (clr) m_acc = 0;
            else if (m_accept) m_acc = (m_acc + int'(m_disp.total) > ACC_MAX) ? ACC_MAX : m_acc + int'(m_disp.total);
            if (m_ovr_evt) m_ovr = 1;
            else if (clr) m_ovr = 0;
            if (m_commit) begin
                m_r = decode(m_s);
                m_committed = m_s;
                m_disp = m_r;
                if (m_ovr_evt && exp_q.size() > 0) exp_q[exp_q.size()-1] = m_r;
                else exp_q.push_back(m_r);
                m_pend = 1;
            end else if (m_accept) begin
                m_pend = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    res_t mon_r;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("out_valid", out_valid_o, m_pend);
            chk("overrun", overrun_o, m_ovr);
            chk("hand_cnt", hand_cnt_o, m_disp.hand);
            chk("total", total_o, m_disp.total);
            chk("acc", acc_o, ACC_EN ? m_acc : 0);
            if (out_valid_o && ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_pending", exp_q.size(), 1);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("sb_hand", hand_cnt_o, mon_r.hand);
                    chk("sb_total", total_o, mon_r.total);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_o) got = 1;
        end
        chk(name, got, 1);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        bit saw;
        saw = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_o) saw = 1;
        end
        chk(name, saw, 0);
    endtask

    logic [HW-1:0] pool[6];
    int            acc_exp[5] = '{52, 104, 156, 208, 255};
    int            lat;
    bit            got;

    initial begin
        @(negedge clk);
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_hand", hand_cnt_o, 0);
        chk("rst_total", total_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_acc", acc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 1: unary decode and commit latency
        ready = 0; mode = 0; hs = {5'b11111, 5'b10101};
        lat = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_o) begin got = 1; lat = i; end
        end
        chk("t1_latency", lat, 6);
        chk("t1_hand", hand_cnt_o, {5'd5, 5'd3});
        chk("t1_total", total_o, 8);
        @(negedge clk); ready = 1;
        repeat (2) @(negedge clk);

        // 2: binary decode via mode change only
        ready = 0; mode = 1;
        wait_valid("t2_valid");
        chk("t2_hand", hand_cnt_o, {5'd31, 5'd21});
        chk("t2_total", total_o, 52);
        @(negedge clk); ready = 1;
        repeat (2) @(negedge clk);

        // 3: three-cycle glitch
        hs = {5'b00000, 5'b11000};
        repeat (3) @(negedge clk);
        hs = {5'b11111, 5'b10101};
        watch_no_valid("t3_no_valid", 12);
        chk("t3_total_held", total_o, 52);

        // 4: overrun with ready low, then clear
        @(negedge clk);
        ready = 0; hs = {5'b00011, 5'b00001};
        repeat (8) @(negedge clk);
        hs = {5'b00100, 5'b00110};
        repeat (8) @(negedge clk);
        #1;
        chk("t4_overrun", overrun_o, 1);
        chk("t4_hand", hand_cnt_o, {5'd4, 5'd6});
        chk("t4_total", total_o, 10);
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0; #1;
        chk("t4_clr", overrun_o, 0);
        ready = 1;
        repeat (2) @(negedge clk);

        // 5: reset mid-settle
        hs = {5'b01110, 5'b10001};
        repeat (2) @(negedge clk);
        rst_n = 0; hs = '0; mode = 0;
        #1;
        chk("t5_valid", out_valid_o, 0);
        chk("t5_total", total_o, 0);
        chk("t5_hand", hand_cnt_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        watch_no_valid("t5_no_commit", 12);

        // 6: accumulator, five accepted totals of 52
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0; mode = 1; ready = 1;
        for (int i = 0; i < 5; i++) begin
            hs = (i % 2 == 0) ? {5'b11111, 5'b10101} : {5'b10101, 5'b11111};
            wait_valid("t6_valid");
            @(posedge clk);
            #1;
            chk("t6_acc", acc_o, ACC_EN ? acc_exp[i] : 0);
            @(negedge clk);
        end
        clr = 1;
        @(negedge clk); clr = 0; #1;
        chk("t6_acc_clr", acc_o, 0);

        // randomized phase
        pool[0] = '0;
        for (int i = 1; i < 6; i++) pool[i] = HW'($urandom);
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end
            hs   = pool[$urandom_range(0, 5)];
            mode = ($urandom_range(0, 3) == 0);
            for (int c = $urandom_range(1, 8); c > 0; c--) begin
                ready = ($urandom_range(0, 3) != 0);
                clr   = ($urandom_range(0, 15) == 0);
                if (c > 1) @(negedge clk);
            end
        end
        @(negedge clk);
        ready = 1; clr = 0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
